// File: rtl/demux1to4_reg_if.sv
// demux1to4_reg_if: producer-side stream plus four consumer channels for the registered 1-to-4 demux
interface demux1to4_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] out_count;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_count
    );
endinterface

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: steers one input stream to four one-entry channel registers with per-channel delivery counters
module demux1to4_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    demux1to4_reg_if.slave bus
);
    logic       rdy;
    logic [3:0] ld;
    logic [3:0] dr;

    // A channel can take a word when empty or draining this cycle; only the selected channel gates the input
    always_comb begin
        rdy          = ~bus.out_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
        bus.in_ready = rdy;
        ld           = (bus.in_valid && rdy) ? 4'(1) << bus.in_sel : 4'b0000;
        dr           = bus.out_valid & bus.out_ready;
    end

    // Per-channel holding register: load on accept, count on drain, valid survives a same-edge drain+load
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= '0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
        end else begin
            bus.out_valid <= ld | (bus.out_valid & ~bus.out_ready);
            for (int n = 0; n < 4; n++) begin
                if (ld[n])
                    bus.out_data[n*WIDTH +: WIDTH] <= bus.in_data;
                if (dr[n])
                    bus.out_count[n*CNT_W +: CNT_W] <= bus.out_count[n*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end
endmodule
